fifo_rd_arbiter: RTL and testbench
==================================

# fifo_rd_arbiter

Read-side scheduler for the FIFO. It shares the single FIFO read port among `N_REQ` consumers using round-robin arbitration with bounded bursts. It generates the read enable and owns the binary read pointer, which advances only on real pops. It sits between the consumers and the FIFO memory/empty-flag logic, in the `rd_clk` domain.

## Interface
Parameters:
- `a_length`, 3: FIFO address width; the pointer is `a_length+1` bits.
- `N_REQ`, 4: number of consumers (2..8).
- `BURST_LEN`, 4: maximum pops per grant before priority rotates (1..15).

Ports (one clock; reset is asynchronous and active-high):
- `rd_clk`  in  1  read-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `f_empty`  in  1  FIFO empty flag, synchronous to `rd_clk`.
- `req`  in  N_REQ  per-consumer read request, level-sensitive.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `rd_en`  out  1  FIFO pop strobe, combinational.
- `rd_ptr`  out  a_length+1  binary read pointer.
- `b_rd_ptr`  out  a_length  memory address, equal to `rd_ptr[a_length-1:0]`.
- `MSB_rd_ptr`  out  1  wrap bit, equal to `rd_ptr[a_length]`.
- `data_valid`  out  1  read data valid at the memory output, registered.
- `data_owner`  out  clog2(N_REQ)  index of the consumer that owns the current `data_valid`.

## Operation
- FSM has two states:
  - IDLE: `gnt` = 0.
  - BURST: exactly one `gnt` bit high.
- Pop rule: `rd_en = (state==BURST) & req[owner] & ~f_empty`. A pop occurs only in a cycle where `rd_en` is high.
- IDLE → BURST:
  - Taken when `|req`.
  - Owner is the first requester searching upward, with wrap, from `last_owner+1`.
  - `gnt` is registered and rises on the next edge. The beat counter clears to 0.
- In BURST, each pop increments the beat counter.
- BURST → IDLE happens on the edge after either of:
  - `req[owner]` low, which releases the grant with no pop.
  - The pop that brings the beat count to `BURST_LEN`.
- On BURST → IDLE: `last_owner <= owner` and `gnt` clears.
- Re-arbitration always passes through IDLE, so there is one dead cycle between grants.
- `f_empty` high in BURST: the owner keeps the grant and stalls with no pop and no beat count. There is no timeout.
- Request changes in non-owners during BURST are ignored until the next IDLE.
- Pointer:
  - `rd_ptr` increments by 1 on the edge following each pop.
  - It wraps modulo 2^(a_length+1), i.e. 7 → 0 on `b_rd_ptr` while `MSB_rd_ptr` toggles.
- Data tagging: `data_valid <= rd_en` and `data_owner <= owner`, giving a fixed one-cycle memory read latency.
- Reset, asynchronous at any time including mid-burst:
  - `state`=IDLE, `gnt`=0, `rd_ptr`=0, `data_valid`=0, `data_owner`=0.
  - Beat counter = 0 and `last_owner=N_REQ-1`, so consumer 0 has first priority.
  - `rd_en` is 0 while reset is asserted.

## Timing
- `req` → `gnt`: 1 cycle from IDLE. `gnt` → first possible pop: same cycle (combinational `rd_en`).
- Pop → `rd_ptr` update: 1 edge. Pop → `data_valid`: 1 edge.
- Full burst of `BURST_LEN` back-to-back pops: `BURST_LEN` cycles. Then 1 IDLE cycle, then the next grant.
- `req[owner]` dropped and `f_empty` rising in the same cycle: release wins, with no pop.
- Final beat and `f_empty` in the same cycle: no pop, the count is not reached, and the grant is held.
- `rd_en` never asserts while `f_empty`=1 or `reset`=1.

## Structure
- Shared package `fifo_pkg`:
  - FSM state encoding (IDLE/BURST).
  - Default `a_length`.
  - `clog2` function used for `data_owner` and beat counter widths.
- Sub-module `fifo_rd_ptr_ctr`: `a_length+1`-bit binary up-counter with enable and asynchronous active-high reset, driven by `rd_en`.
- Arbiter, FSM and tagging are in the top module.

## Test plan
- Reset, then `req`=0001 with FIFO holding 8 entries:
  - `gnt`=0001 one cycle later.
  - 4 pops; `rd_ptr` goes 0 → 4; `data_valid` high for 4 cycles with `data_owner`=0.
  - `gnt`=0 for 1 cycle, then `gnt`=0001 again.
- `req`=1111 held, FIFO always non-empty:
  - Grant order is 0, 1, 2, 3, 0, 4 pops each, with 1 IDLE cycle between grants.
  - `rd_ptr` wraps 15 → 0 after 16 pops, with `MSB_rd_ptr` toggling at pops 8 and 16.
- Owner 2 granted, `f_empty` forced high for 5 cycles after 2 pops:
  - `gnt` stays 0100 and `rd_en`=0 for those cycles.
  - After `f_empty` falls, exactly 2 more pops occur, then release.
- Owner 1 drops `req` after 1 pop while `req[3]` is high:
  - `gnt` goes 0 for 1 cycle, then 1000.
  - `rd_ptr` advanced by exactly 1 during owner 1's grant.
- `reset` asserted mid-burst (after 2 pops, `rd_ptr`=2):
  - Immediately `gnt`=0, `rd_en`=0, `rd_ptr`=0.
  - After release with `req`=1010, the first grant goes to consumer 1.
- Same-cycle final beat and `f_empty`=1 (`BURST_LEN`=4, 3 pops done):
  - No pop and grant held.
  - 4th pop occurs when `f_empty` falls, then release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side logic.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_pkg;

   // Read scheduler FSM: either no grant is held, or exactly one consumer owns the port.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } rd_state_t;

   // Default FIFO address width; the read pointer carries one extra wrap bit.
   localparam int A_LENGTH_DEF = 3;

   // Ceiling log2, never below 1 so that derived vectors always have a legal width.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (r = 0; (1 << r) < value; r++) begin
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rd_ptr_ctr.sv
// Binary read pointer: free-running up-counter that advances on each pop.
// Latency: count updates on the edge after i_en.
// Backpressure: none; the caller gates i_en to real pops only.
module fifo_rd_ptr_ctr #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   // Count pops; natural overflow gives the modulo-2^WIDTH wrap with the MSB toggling.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-port scheduler with bounded bursts; owns rd_en and the read pointer.
// Latency: req->gnt 1 cycle from IDLE; rd_en same cycle as gnt; rd_ptr/data_valid 1 edge after a pop.
// Backpressure: f_empty stalls the owner (grant held, no pop); a dropped owner request releases the grant.
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int a_length  = A_LENGTH_DEF,
   parameter int N_REQ     = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                      rd_clk,
   input  logic                      reset,
   input  logic                      f_empty,
   input  logic [N_REQ-1:0]          req,
   output logic [N_REQ-1:0]          gnt,
   output logic                      rd_en,
   output logic [a_length:0]         rd_ptr,
   output logic [a_length-1:0]       b_rd_ptr,
   output logic                      MSB_rd_ptr,
   output logic                      data_valid,
   output logic [clog2(N_REQ)-1:0]   data_owner
);

   localparam int OW = clog2(N_REQ);
   localparam int BW = clog2(BURST_LEN + 1);

   rd_state_t         r_state;
   logic [N_REQ-1:0]  r_gnt;
   logic [OW-1:0]     r_owner;
   logic [OW-1:0]     r_last_owner;
   logic [BW-1:0]     r_beat;
   logic              r_data_valid;
   logic [OW-1:0]     r_data_owner;

   logic              w_any_req;
   logic              w_owner_req;
   logic              w_last_beat;
   logic              w_rd_en;
   logic              w_release;
   logic [OW-1:0]     w_pick;
   logic [N_REQ-1:0]  w_pick_onehot;
   logic [a_length:0] w_rd_ptr;

   // First requester searching upward from last+1 with wrap; falls back to last
   // when nothing is requesting (the result is only used when some req is set).
   function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] reqs,
                                             input logic [OW-1:0]    last);
      logic [OW-1:0] pick;
      logic [OW:0]   idx;
      logic          found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = {1'b0, last} + (OW+1)'(k);
         if (idx >= (OW+1)'(N_REQ)) begin
            idx = idx - (OW+1)'(N_REQ);
         end
         if (!found && reqs[idx[OW-1:0]]) begin
            pick  = idx[OW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign w_any_req     = |req;
   assign w_owner_req   = req[r_owner];
   assign w_last_beat   = (r_beat == BW'(BURST_LEN - 1));
   assign w_pick        = rr_pick(req, r_last_owner);
   assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

   // Pop only while a burst is active, the owner still asks, and the FIFO has data.
   // Reset is folded in so the strobe is dead for the whole reset window.
   assign w_rd_en = (r_state == ST_BURST) & w_owner_req & ~f_empty & ~reset;

   // A dropped owner request wins over everything (no pop that cycle); otherwise
   // the burst ends only on the pop that completes BURST_LEN beats.
   assign w_release = (r_state == ST_BURST) & (~w_owner_req | (w_rd_en & w_last_beat));

   // Grant FSM: arbitrate from IDLE, count beats in BURST, always fall back to IDLE between owners.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_gnt        <= '0;
         r_owner      <= '0;
         r_last_owner <= OW'(N_REQ - 1);
         r_beat       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state <= ST_BURST;
                  r_owner <= w_pick;
                  r_gnt   <= w_pick_onehot;
                  r_beat  <= '0;
               end
            end
            ST_BURST: begin
               if (w_release) begin
                  r_state      <= ST_IDLE;
                  r_gnt        <= '0;
                  r_last_owner <= r_owner;
                  r_beat       <= '0;
               end else if (w_rd_en) begin
                  r_beat <= r_beat + BW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   // Tag memory output: the RAM returns data one cycle after the pop, owned by the current granted consumer.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         r_data_valid <= 1'b0;
         r_data_owner <= '0;
      end else begin
         r_data_valid <= w_rd_en;
         r_data_owner <= r_owner;
      end
   end

   fifo_rd_ptr_ctr #(
      .WIDTH (a_length + 1)
   ) u_rd_ptr_ctr (
      .i_clk (rd_clk),
      .i_rst (reset),
      .i_en  (w_rd_en),
      .o_cnt (w_rd_ptr)
   );

   assign gnt        = r_gnt;
   assign rd_en      = w_rd_en;
   assign rd_ptr     = w_rd_ptr;
   assign b_rd_ptr   = w_rd_ptr[a_length-1:0];
   assign MSB_rd_ptr = w_rd_ptr[a_length];
   assign data_valid = r_data_valid;
   assign data_owner = r_data_owner;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: table vectors, directed corner sequences and
// randomized traffic, all cross-checked every cycle against a queue-free
// behavioural model of the grant/burst/pointer rules.
module tb_fifo_rd_arbiter;

   localparam int AL = 3;
   localparam int NR = 4;
   localparam int BL = 4;
   localparam int OW = 2;

   logic          rd_clk = 1'b0;
   logic          reset;
   logic          f_empty;
   logic [NR-1:0] req;
   logic [NR-1:0] gnt;
   logic          rd_en;
   logic [AL:0]   rd_ptr;
   logic [AL-1:0] b_rd_ptr;
   logic          MSB_rd_ptr;
   logic          data_valid;
   logic [OW-1:0] data_owner;

   int n_chk = 0;
   int n_bad = 0;

   // last sampled DUT outputs (taken 1 time unit after the negative edge)
   logic [NR-1:0] s_gnt;
   logic          s_rd_en;
   logic [AL:0]   s_ptr;
   logic          s_dv;
   logic [OW-1:0] s_downer;

   // behavioural model state
   bit m_busy;
   int m_owner;
   int m_last;
   int m_left;
   int m_ptr;
   int m_dv;
   int m_downer;

   typedef struct {
      logic [NR-1:0] req;
      logic          fe;
      logic [NR-1:0] gnt;
      logic          rd_en;
      int            ptr;
      logic          dv;
      int            downer;
   } vec_t;

   vec_t tbl[7];

   fifo_rd_arbiter #(
      .a_length  (AL),
      .N_REQ     (NR),
      .BURST_LEN (BL)
   ) dut (
      .rd_clk     (rd_clk),
      .reset      (reset),
      .f_empty    (f_empty),
      .req        (req),
      .gnt        (gnt),
      .rd_en      (rd_en),
      .rd_ptr     (rd_ptr),
      .b_rd_ptr   (b_rd_ptr),
      .MSB_rd_ptr (MSB_rd_ptr),
      .data_valid (data_valid),
      .data_owner (data_owner)
   );

   always #5 rd_clk = ~rd_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_owner  = 0;
      m_last   = NR - 1;
      m_left   = 0;
      m_ptr    = 0;
      m_dv     = 0;
      m_downer = 0;
   endtask

   // One clock edge of the scheduling rules, from the inputs seen before the edge.
   task automatic model_step(input logic [NR-1:0] r, input logic fe);
      bit pop;
      bit found;
      pop      = m_busy && r[m_owner] && !fe;
      m_dv     = pop ? 1 : 0;
      m_downer = m_owner;
      if (pop) m_ptr = (m_ptr + 1) % (1 << (AL + 1));
      if (m_busy) begin
         if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
         end else if (pop) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end
      end else if (r != '0) begin
         found = 1'b0;
         for (int k = 1; k <= NR; k++) begin
            if (!found && r[(m_last + k) % NR]) begin
               m_owner = (m_last + k) % NR;
               found   = 1'b1;
            end
         end
         m_busy = 1'b1;
         m_left = BL;
      end
   endtask

   // Entered at a negative edge: drive, sample and compare with the model, cross one posedge.
   task automatic step(input logic [NR-1:0] r, input logic fe);
      int exp_gnt;
      int exp_rd;
      req     = r;
      f_empty = fe;
      #1;
      s_gnt    = gnt;
      s_rd_en  = rd_en;
      s_ptr    = rd_ptr;
      s_dv     = data_valid;
      s_downer = data_owner;
      exp_gnt  = m_busy ? (1 << m_owner) : 0;
      exp_rd   = (m_busy && r[m_owner] && !fe) ? 1 : 0;
      check("model_gnt", gnt, exp_gnt);
      check("model_rd_en", rd_en, exp_rd);
      check("model_rd_ptr", rd_ptr, m_ptr);
      check("model_b_rd_ptr", b_rd_ptr, m_ptr % (1 << AL));
      check("model_msb", MSB_rd_ptr, m_ptr >> AL);
      check("model_data_valid", data_valid, m_dv);
      check("model_data_owner", data_owner, m_downer);
      @(posedge rd_clk);
      model_step(r, fe);
      @(negedge rd_clk);
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      req     = '0;
      f_empty = 1'b0;
      model_reset();
      @(negedge rd_clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [NR-1:0] exp_ord[5];
      logic [NR-1:0] ord[$];
      logic [NR-1:0] prev_g;
      logic [NR-1:0] rr;
      logic          fe;
      int            pops;

      tbl[0] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 0};
      tbl[1] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 0};
      tbl[2] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1, 1'b1, 0};
      tbl[3] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2, 1'b1, 0};
      tbl[4] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 3, 1'b1, 0};
      tbl[5] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4, 1'b1, 0};
      tbl[6] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 4, 1'b0, 0};

      // reset state, with every consumer requesting so rd_en must still stay low
      reset   = 1'b1;
      req     = 4'b1111;
      f_empty = 1'b0;
      model_reset();
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_ptr", rd_ptr, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_data_owner", data_owner, 0);
      @(negedge rd_clk);
      reset = 1'b0;

      // single requester, one full burst then the re-grant after a dead cycle
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].req, tbl[i].fe);
         check($sformatf("tbl%0d_gnt", i), s_gnt, tbl[i].gnt);
         check($sformatf("tbl%0d_rd_en", i), s_rd_en, tbl[i].rd_en);
         check($sformatf("tbl%0d_rd_ptr", i), s_ptr, tbl[i].ptr);
         check($sformatf("tbl%0d_dv", i), s_dv, tbl[i].dv);
         check($sformatf("tbl%0d_downer", i), s_downer, tbl[i].downer);
      end

      // all requesting: rotation 0,1,2,3,0 and pointer wrap after 16 pops
      apply_reset();
      exp_ord[0] = 4'b0001;
      exp_ord[1] = 4'b0010;
      exp_ord[2] = 4'b0100;
      exp_ord[3] = 4'b1000;
      exp_ord[4] = 4'b0001;
      ord.delete();
      prev_g = '0;
      pops   = 0;
      for (int c = 0; c < 24; c++) begin
         step(4'b1111, 1'b0);
         if (pops == 8) begin
            check("rr_msb_at8", {s_ptr[AL], s_ptr[AL-1:0]}, {1'b1, 3'd0});
         end
         if (pops == 16) begin
            check("rr_wrap_at16", s_ptr, 0);
         end
         if (s_rd_en) pops++;
         if (s_gnt != '0 && prev_g == '0) ord.push_back(s_gnt);
         prev_g = s_gnt;
      end
      check("rr_grant_count", ord.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < ord.size()) check($sformatf("rr_order%0d", i), ord[i], exp_ord[i]);
      end

      // owner 2 stalls on empty for 5 cycles after 2 pops, then finishes 2 more
      apply_reset();
      step(4'b0100, 1'b0);
      check("stall_idle_gnt", s_gnt, 0);
      step(4'b0100, 1'b0);
      check("stall_gnt", s_gnt, 4'b0100);
      step(4'b0100, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(4'b0100, 1'b1);
         check("stall_hold_gnt", s_gnt, 4'b0100);
         check("stall_no_pop", s_rd_en, 0);
      end
      step(4'b0100, 1'b0);
      check("stall_pop3", s_rd_en, 1);
      step(4'b0100, 1'b0);
      check("stall_pop4", s_rd_en, 1);
      step(4'b0100, 1'b0);
      check("stall_release_gnt", s_gnt, 0);
      check("stall_ptr", s_ptr, 4);

      // owner 1 drops after one pop; consumer 3 is next
      apply_reset();
      step(4'b1010, 1'b0);
      step(4'b1010, 1'b0);
      check("drop_gnt1", s_gnt, 4'b0010);
      check("drop_pop", s_rd_en, 1);
      step(4'b1000, 1'b0);
      check("drop_no_pop", s_rd_en, 0);
      step(4'b1000, 1'b0);
      check("drop_idle", s_gnt, 0);
      step(4'b1000, 1'b0);
      check("drop_gnt3", s_gnt, 4'b1000);
      check("drop_ptr", s_ptr, 1);

      // asynchronous reset in the middle of a burst
      apply_reset();
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      #1;
      check("mid_ptr_before", rd_ptr, 2);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_gnt", gnt, 0);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_ptr", rd_ptr, 0);
      check("mid_rst_dv", data_valid, 0);
      model_reset();
      @(negedge rd_clk);
      reset = 1'b0;
      step(4'b1010, 1'b0);
      step(4'b1010, 1'b0);
      check("mid_first_gnt", s_gnt, 4'b0010);

      // final beat coincides with empty: held, then the 4th pop, then release
      apply_reset();
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b1);
      check("last_empty_no_pop", s_rd_en, 0);
      check("last_empty_gnt", s_gnt, 4'b0001);
      step(4'b0001, 1'b1);
      check("last_empty_gnt2", s_gnt, 4'b0001);
      step(4'b0001, 1'b0);
      check("last_pop", s_rd_en, 1);
      step(4'b0001, 1'b0);
      check("last_release", s_gnt, 0);
      check("last_ptr", s_ptr, 4);

      // randomized traffic against the model, with occasional resets
      apply_reset();
      rr = 4'($urandom_range(0, 15));
      for (int c = 0; c < 800; c++) begin
         if (c % 200 == 199) apply_reset();
         if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
         fe = ($urandom_range(0, 3) == 0);
         step(rr, fe);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
